// File: rtl/rx_byte_buffer_if.sv
// Channel-side receive beat plus the downstream valid/ready drain port of rx_byte_buffer.
// With RX_PASS_ERRORED_EN defined, out_err travels with the head byte.
interface rx_byte_buffer_if;
  logic [7:0] rx_data;
  logic       rx_error;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef RX_PASS_ERRORED_EN
  logic       out_err;

  modport master (output rx_data, rx_error, rx_valid, out_ready,
                  input  out_data, out_valid, out_err);
  modport slave  (input  rx_data, rx_error, rx_valid, out_ready,
                  output out_data, out_valid, out_err);
`else
  modport master (output rx_data, rx_error, rx_valid, out_ready,
                  input  out_data, out_valid);
  modport slave  (input  rx_data, rx_error, rx_valid, out_ready,
                  output out_data, out_valid);
`endif
endinterface

// File: rtl/rx_byte_buffer.sv
// Receive byte buffer: show-ahead FIFO fed by the channel, error-burst retransmit FSM.
// Optional macro RX_PASS_ERRORED_EN: errored beats are stored with a per-entry error flag.
module rx_byte_buffer #(
  parameter int DEPTH      = 8,
  parameter int ERR_THRESH = 3,
  parameter int HOLDOFF    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  rx_byte_buffer_if.slave        bus,
  output logic                   retx_req,
  output logic                   overflow,
  output logic [7:0]             err_count,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   resync
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ERR_THRESH + 1);
  localparam int HW = $clog2(HOLDOFF + 1);
`ifdef RX_PASS_ERRORED_EN
  localparam int  EW   = 9;
  localparam bit  PASS = 1'b1;
`else
  localparam int  EW   = 8;
  localparam bit  PASS = 1'b0;
`endif

  typedef enum logic {NORMAL, RESYNC} state_t;

  state_t                     state_q, state_d;
  logic [HW-1:0]              hold_q, hold_d;
  logic [CW-1:0]              cons_q, cons_d;
  logic                       retx_q, retx_d;

  logic [DEPTH-1:0][EW-1:0]   mem_q;
  logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [AW:0]                level_q;
  logic                       ovf_q;
  logic [7:0]                 errc_q;

  logic                       full, pop, push, drop, accept, trigger, is_normal;
  logic [CW-1:0]              cons_inc;
  logic [EW-1:0]              wr_entry, head;

  assign is_normal = (state_q == NORMAL);
  assign full      = (level_q == (AW+1)'(DEPTH));
  assign pop       = (level_q != '0) & bus.out_ready;
  // Beats eligible for storage; RESYNC blocks everything.
  assign accept    = is_normal & bus.rx_valid & (PASS | ~bus.rx_error);
  assign push      = accept & (~full | pop);
  assign drop      = accept & full & ~pop;
  assign cons_inc  = cons_q + 1'b1;
  assign trigger   = is_normal & bus.rx_valid & bus.rx_error & (cons_inc == CW'(ERR_THRESH));

`ifdef RX_PASS_ERRORED_EN
  assign wr_entry    = {bus.rx_error, bus.rx_data};
  assign bus.out_err = head[8];
`else
  assign wr_entry    = bus.rx_data;
`endif
  assign head         = mem_q[rd_ptr_q];
  assign bus.out_data = head[7:0];
  assign bus.out_valid = (level_q != '0);
  assign fifo_level   = level_q;
  assign overflow     = ovf_q;
  assign err_count    = errc_q;

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= NORMAL;
      hold_q  <= '0;
      cons_q  <= '0;
      retx_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cons_q  <= cons_d;
      retx_q  <= retx_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cons_d  = cons_q;
    retx_d  = 1'b0;
    case (state_q)
      NORMAL: begin
        if (trigger) begin
          state_d = RESYNC;
          hold_d  = '0;
          cons_d  = '0;
          retx_d  = 1'b1;
        end else if (bus.rx_valid) begin
          cons_d = bus.rx_error ? cons_inc : '0;
        end
      end
      RESYNC: begin
        if (hold_q == HW'(HOLDOFF - 1)) state_d = NORMAL;
        else                            hold_d  = hold_q + 1'b1;
      end
      default: state_d = NORMAL;
    endcase
  end

  // FSM: outputs (retx_q marks the first RESYNC cycle)
  always_comb begin
    resync   = (state_q == RESYNC);
    retx_req = retx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      errc_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (drop) ovf_q <= 1'b1;
      if (bus.rx_valid && bus.rx_error && errc_q != 8'hFF) errc_q <= errc_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_rx_byte_buffer.sv
// Directed bench for rx_byte_buffer; expectations are hand-computed per scenario.
// Works with or without RX_PASS_ERRORED_EN defined.
module tb_rx_byte_buffer;
`ifdef RX_PASS_ERRORED_EN
  localparam bit PASS = 1'b1;
`else
  localparam bit PASS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       retx_req, overflow, resync;
  logic [7:0] err_count;
  logic [3:0] fifo_level;
  int         total = 0;
  int         bad   = 0;

  rx_byte_buffer_if bus ();

  rx_byte_buffer #(.DEPTH(8), .ERR_THRESH(3), .HOLDOFF(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .retx_req   (retx_req),
    .overflow   (overflow),
    .err_count  (err_count),
    .fifo_level (fifo_level),
    .resync     (resync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    bus.rx_valid = 1'b1; bus.rx_data = d; bus.rx_error = e;
    tick();
    bus.rx_valid = 1'b0; bus.rx_error = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; bus.out_ready = 1'b0; bus.rx_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  initial begin
    bus.rx_data = '0; bus.rx_error = 1'b0; bus.rx_valid = 1'b0; bus.out_ready = 1'b0;
    #2;
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_retx", retx_req, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_errc", err_count, 8'd0);
    chk("rst_resync", resync, 1'b0);
    do_reset();

    // 1: basic in-order push/pop
    push(8'hAA, 0); push(8'hCC, 0); push(8'hF0, 0);
    chk("t1_level", fifo_level, 4'd3);
    chk("t1_head", bus.out_data, 8'hAA);
    bus.out_ready = 1'b1;
    chk("t1_pop0", bus.out_data, 8'hAA); tick();
    chk("t1_pop1", bus.out_data, 8'hCC); tick();
    chk("t1_pop2", bus.out_data, 8'hF0); tick();
    chk("t1_empty", bus.out_valid, 1'b0);
    chk("t1_level0", fifo_level, 4'd0);
    bus.out_ready = 1'b0;

    // 2: single errored beat dropped, no retransmit
    do_reset();
    push(8'h01, 0); chk("t2_retx0", retx_req, 1'b0);
    push(8'h55, 1); chk("t2_retx1", retx_req, 1'b0);
    push(8'h92, 0); chk("t2_retx2", retx_req, 1'b0);
    chk("t2_errc", err_count, 8'd1);
    chk("t2_level", fifo_level, PASS ? 4'd3 : 4'd2);
    bus.out_ready = 1'b1;
    chk("t2_pop0", bus.out_data, 8'h01); tick();
    if (PASS) begin
      chk("t2_pop1e", bus.out_data, 8'h55); tick();
    end
    chk("t2_pop2", bus.out_data, 8'h92); tick();
    chk("t2_empty", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;

    // 3: error burst -> retransmit + RESYNC holdoff
    do_reset();
    push(8'hE0, 1); chk("t3_retx_a", retx_req, 1'b0);
    push(8'hFF, 1); chk("t3_retx_b", retx_req, 1'b0);
    push(8'h2A, 1);
    chk("t3_retx_c1", retx_req, 1'b1);
    chk("t3_rs_c1", resync, 1'b1);
    push(8'h1C, 0);
    chk("t3_retx_c2", retx_req, 1'b0);
    chk("t3_rs_c2", resync, 1'b1);
    push(8'h77, 1);
    chk("t3_rs_c3", resync, 1'b1);
    chk("t3_errc_rs", err_count, 8'd4);
    tick();
    chk("t3_rs_c4", resync, 1'b1);
    chk("t3_retx_c4", retx_req, 1'b0);
    tick();
    chk("t3_rs_end", resync, 1'b0);
    chk("t3_level_rs", fifo_level, PASS ? 4'd3 : 4'd0);
    push(8'h1C, 0);
    chk("t3_level", fifo_level, PASS ? 4'd4 : 4'd1);
    chk("t3_head", bus.out_data, PASS ? 8'hE0 : 8'h1C);
    chk("t3_errc", err_count, 8'd4);

    // 4: overflow and full push+pop
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 0);
    chk("t4_full", fifo_level, 4'd8);
    chk("t4_ovf0", overflow, 1'b0);
    push(8'h0F, 0);
    chk("t4_ovf1", overflow, 1'b1);
    chk("t4_level", fifo_level, 4'd8);
    chk("t4_head", bus.out_data, 8'h10);
    bus.out_ready = 1'b1;
    push(8'h33, 0);
    bus.out_ready = 1'b0;
    chk("t4_level_pp", fifo_level, 4'd8);
    chk("t4_head_pp", bus.out_data, 8'h11);
    chk("t4_ovf_sticky", overflow, 1'b1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bus.out_ready = 1'b0;
    chk("t4_tail", bus.out_data, 8'h33);
    chk("t4_level1", fifo_level, 4'd1);

    // 5: async reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i), 0);
    push(8'hE1, 1); push(8'hE2, 1); push(8'hE3, 1);
    chk("t5_level", fifo_level, PASS ? 4'd8 : 4'd5);
    chk("t5_rs", resync, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t5_data", bus.out_data, 8'h00);
    chk("t5_valid", bus.out_valid, 1'b0);
    chk("t5_lvl0", fifo_level, 4'd0);
    chk("t5_rs0", resync, 1'b0);
    chk("t5_retx0", retx_req, 1'b0);
    chk("t5_errc0", err_count, 8'd0);
    @(negedge clk) rst = 1'b1;
    tick();
    push(8'hCC, 0);
    chk("t5_head", bus.out_data, 8'hCC);
    chk("t5_valid1", bus.out_valid, 1'b1);

`ifdef RX_PASS_ERRORED_EN
    // 6: errored bytes carried through with flag
    do_reset();
    push(8'hCC, 0); push(8'h0F, 1);
    bus.out_ready = 1'b1;
    chk("t6_d0", bus.out_data, 8'hCC);
    chk("t6_e0", bus.out_err, 1'b0);
    tick();
    chk("t6_d1", bus.out_data, 8'h0F);
    chk("t6_e1", bus.out_err, 1'b1);
    tick();
    bus.out_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
